// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
// Segment order is {g,f,e,d,c,b,a}; anodes and segments are active-low.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Element [0] is the rightmost digit (an[0] low).
    localparam logic [3:0][3:0] AN_DIG = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Element [n] is the glyph for nibble n; b and d are lower case.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Scans a 4-digit multiplexed 7-segment display right to left with guard blanking,
// double-buffering loaded values so they only take effect at frame boundaries.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DWELL_CYCLES    = 4,
    parameter int BLANK_CYCLES    = 1,
    parameter bit LEAD_ZERO_BLANK = 1'b1
) (
    input  logic        div_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        err_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_MAX = max_int(DWELL_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_end;

    logic [15:0]      disp_val_q, disp_val_d;
    logic             disp_err_q, disp_err_d;
    logic [15:0]      pend_val_q;
    logic             pend_err_q;
    logic             pend_full_q;

    logic             accept;
    logic             transfer;

    logic [3:0]       nibble_d;
    logic             lead_blank_d;
    logic [6:0]       glyph_d;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    assign load_ready = ~pend_full_q;
    assign accept     = load_valid & load_ready;
    assign transfer   = frame_end & pend_full_q;

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            digit_d = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d   = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                        digit_d   = digit_q + 2'd1;
                        cnt_d     = '0;
                        frame_end = (digit_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next-cycle state so they register on the same edge.
    always_comb begin
        disp_val_d   = transfer ? pend_val_q : disp_val_q;
        disp_err_d   = transfer ? pend_err_q : disp_err_q;
        nibble_d     = disp_val_d[3:0];
        lead_blank_d = 1'b0;
        case (digit_d)
            2'd0: begin
                nibble_d     = disp_val_d[3:0];
                lead_blank_d = 1'b0;
            end
            2'd1: begin
                nibble_d     = disp_val_d[7:4];
                lead_blank_d = (disp_val_d[15:4] == 12'd0);
            end
            2'd2: begin
                nibble_d     = disp_val_d[11:8];
                lead_blank_d = (disp_val_d[15:8] == 8'd0);
            end
            default: begin
                nibble_d     = disp_val_d[15:12];
                lead_blank_d = (disp_val_d[15:12] == 4'd0);
            end
        endcase
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            an_d  = AN_DIG[digit_d];
            seg_d = (LEAD_ZERO_BLANK && lead_blank_d) ? SEG_OFF : glyph_d;
            dp_d  = ~((digit_d == 2'd0) & disp_err_d);
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble_d),
        .seg    (glyph_d)
    );

    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            state_q    <= BLANK;
            digit_q    <= 2'd0;
            cnt_q      <= '0;
            disp_val_q <= 16'd0;
            disp_err_q <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            cnt_q      <= cnt_d;
            disp_val_q <= disp_val_d;
            disp_err_q <= disp_err_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= frame_end;
        end
    end

    // A load on the transfer edge is only possible when the buffer was already empty.
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            pend_full_q <= 1'b0;
            pend_val_q  <= 16'd0;
            pend_err_q  <= 1'b0;
        end else if (transfer) begin
            pend_full_q <= 1'b0;
        end else if (accept) begin
            pend_full_q <= 1'b1;
            pend_val_q  <= value_in;
            pend_err_q  <= err_in;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed self-checking bench for seven_seg_display_ctrl with default parameters.
// Cycle cN is sampled on the falling edge just before rising edge N after reset release.
module tb_seven_seg_display_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       rdy;
    } vec_t;

    logic        div_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value_in;
    logic        err_in;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    vec_t tbl[$];

    seven_seg_display_ctrl dut (
        .div_clock  (div_clock),
        .reset      (reset),
        .enable     (enable),
        .value_in   (value_in),
        .err_in     (err_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 div_clock = ~div_clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s @c%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic vld, input logic [15:0] val,
                                 input logic err);
        enable     = en;
        load_valid = vld;
        value_in   = val;
        err_in     = err;
    endtask

    task automatic step();
        @(negedge div_clock);
        cyc++;
    endtask

    task automatic goTo(input int c);
        while (cyc < c) step();
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(negedge div_clock);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic addRow(input int c, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic f, input logic r);
        vec_t v;
        v.cyc = c; v.an = a; v.seg = s; v.dp = d; v.fd = f; v.rdy = r;
        tbl.push_back(v);
    endtask

    task automatic checkDisplay(input string tag, input logic [3:0] a, input logic [6:0] s,
                                input logic d);
        checkOutput({tag, "_an"}, 32'(an), 32'(a));
        checkOutput({tag, "_seg"}, 32'(seg), 32'(s));
        checkOutput({tag, "_dp"}, 32'(dp), 32'(d));
    endtask

    initial begin
        int idx;
        int fdBad;

        // Scan timing with a 0xBEEF/err load at c7 that shows from the second frame.
        addRow(0,  4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
        addRow(1,  4'hE, 7'h40, 1'b1, 1'b0, 1'b1);
        addRow(4,  4'hE, 7'h40, 1'b1, 1'b0, 1'b1);
        addRow(5,  4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
        addRow(6,  4'hD, 7'h7F, 1'b1, 1'b0, 1'b1);
        addRow(8,  4'hD, 7'h7F, 1'b1, 1'b0, 1'b0);
        addRow(10, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        addRow(11, 4'hB, 7'h7F, 1'b1, 1'b0, 1'b0);
        addRow(15, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        addRow(16, 4'h7, 7'h7F, 1'b1, 1'b0, 1'b0);
        addRow(19, 4'h7, 7'h7F, 1'b1, 1'b0, 1'b0);
        addRow(20, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);
        addRow(21, 4'hE, 7'h0E, 1'b0, 1'b0, 1'b1);
        addRow(24, 4'hE, 7'h0E, 1'b0, 1'b0, 1'b1);
        addRow(25, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
        addRow(26, 4'hD, 7'h06, 1'b1, 1'b0, 1'b1);
        addRow(31, 4'hB, 7'h06, 1'b1, 1'b0, 1'b1);
        addRow(36, 4'h7, 7'h03, 1'b1, 1'b0, 1'b1);
        addRow(39, 4'h7, 7'h03, 1'b1, 1'b0, 1'b1);
        addRow(40, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);
        addRow(41, 4'hE, 7'h0E, 1'b0, 1'b0, 1'b1);

        doReset();
        idx   = 0;
        fdBad = 0;
        for (int c = 0; c <= 41; c++) begin
            while (idx < tbl.size() && tbl[idx].cyc == c) begin
                checkDisplay("scan", tbl[idx].an, tbl[idx].seg, tbl[idx].dp);
                checkOutput("scan_frame_done", 32'(frame_done), 32'(tbl[idx].fd));
                checkOutput("scan_ready", 32'(load_ready), 32'(tbl[idx].rdy));
                idx++;
            end
            if (c != 20 && c != 40 && frame_done !== 1'b0) fdBad++;
            if (c == 7) applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b1);
            if (c == 8) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
            step();
        end
        checkOutput("scan_frame_done_quiet", 32'(fdBad), 32'd0);

        // Held load while the buffer is full waits for ready; leading-zero blanking.
        doReset();
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0);
        step();
        checkOutput("hold_ready_c1", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
        goTo(19);
        checkOutput("hold_ready_c19", 32'(load_ready), 32'd0);
        goTo(20);
        checkOutput("hold_ready_c20", 32'(load_ready), 32'd1);
        checkOutput("hold_frame_done", 32'(frame_done), 32'd1);
        step();
        checkOutput("hold_accepted", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkDisplay("lzb40_d0", 4'hE, 7'h40, 1'b1);
        goTo(26);
        checkDisplay("lzb40_d1", 4'hD, 7'h19, 1'b1);
        goTo(31);
        checkDisplay("lzb40_d2", 4'hB, 7'h7F, 1'b1);
        goTo(36);
        checkDisplay("lzb40_d3", 4'h7, 7'h7F, 1'b1);
        goTo(40);
        checkOutput("lzb_frame_done", 32'(frame_done), 32'd1);
        checkOutput("lzb_ready", 32'(load_ready), 32'd1);
        goTo(41);
        checkDisplay("lzb0_d0", 4'hE, 7'h40, 1'b1);
        goTo(46);
        checkDisplay("lzb0_d1", 4'hD, 7'h7F, 1'b1);
        goTo(51);
        checkDisplay("lzb0_d2", 4'hB, 7'h7F, 1'b1);

        // Disable mid-frame, load while idle, re-enable and run a fresh frame of 0x1234.
        doReset();
        fdBad = 0;
        while (cyc < 8) begin
            if (frame_done !== 1'b0) fdBad++;
            step();
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        checkDisplay("dis_dark", 4'hF, 7'h7F, 1'b1);
        goTo(10);
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("idle_load_ready", 32'(load_ready), 32'd0);
        checkDisplay("idle_dark", 4'hF, 7'h7F, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        checkDisplay("reen_blank", 4'hF, 7'h7F, 1'b1);
        step();
        checkDisplay("reen_d0", 4'hE, 7'h40, 1'b1);
        while (cyc < 33) begin
            if (frame_done !== 1'b0) fdBad++;
            step();
        end
        checkOutput("reen_frame_done_quiet", 32'(fdBad), 32'd0);
        checkOutput("reen_frame_done", 32'(frame_done), 32'd1);
        checkOutput("reen_ready", 32'(load_ready), 32'd1);
        goTo(34);
        checkDisplay("v1234_d0", 4'hE, 7'h19, 1'b1);
        goTo(39);
        checkDisplay("v1234_d1", 4'hD, 7'h30, 1'b1);
        goTo(44);
        checkDisplay("v1234_d2", 4'hB, 7'h24, 1'b1);
        goTo(49);
        checkDisplay("v1234_d3", 4'h7, 7'h79, 1'b1);

        // Asynchronous reset while digit 2 is driven and the buffer holds a value.
        doReset();
        applyStimulus(1'b1, 1'b1, 16'h00FF, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        goTo(12);
        checkOutput("pre_rst_an", 32'(an), 32'hB);
        checkOutput("pre_rst_ready", 32'(load_ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        checkDisplay("async_rst", 4'hF, 7'h7F, 1'b1);
        checkOutput("async_rst_ready", 32'(load_ready), 32'd1);
        checkOutput("async_rst_fd", 32'(frame_done), 32'd0);
        @(negedge div_clock);
        reset = 1'b0;
        cyc   = 0;
        goTo(1);
        checkDisplay("post_rst_d0", 4'hE, 7'h40, 1'b1);
        goTo(20);
        checkOutput("post_rst_frame_done", 32'(frame_done), 32'd1);
        goTo(21);
        checkDisplay("post_rst_lost", 4'hE, 7'h40, 1'b1);
        goTo(26);
        checkDisplay("post_rst_d1", 4'hD, 7'h7F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
